reg_file_scoreboard: RTL and testbench



---
 rtl/reg_file_scoreboard_pkg.sv | 13 +
 rtl/reg_file_scoreboard.sv | 159 +++++++++++++++
 tb/tb_reg_file_scoreboard.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard_pkg
// Shared core constants for the integer register file with pending-write
// scoreboard: default data width, default register count and the index of
// the hardwired-zero register.
// -----------------------------------------------------------------------------
package reg_file_scoreboard_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;

endpackage : reg_file_scoreboard_pkg

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard
// Parametrised integer register file with write-to-read bypass and a
// pending-write scoreboard. A busy bit per register records an in-flight
// producer, letting the control unit stall on RAW/WAW hazards.
// Register 0 reads as zero and is never busy.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rs1_addr/rs2_addr    read addresses
//   rs1_data/rs2_data    combinational read data (with writeback bypass)
//   rs1_ready/rs2_ready  operand has no pending producer, or is written now
//   issue_valid/issue_rd instruction issuing with destination issue_rd
//   issue_ready          issue would be accepted this cycle
//   wb_valid/wb_rd/wb_data writeback strobe, destination and data
//   flush                discard all pending producers
//   busy_cnt             registered number of busy registers
//   wb_err               registered pulse: writeback to a non-busy register
// -----------------------------------------------------------------------------
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_cnt,
  output logic            wb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             wb_err_q;
  logic             wb_err_d;
  // Remembers a flush so that stale writebacks right after it are not errors.
  logic             flush_q;
  logic             flush_d;

  logic wb_write;
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_issue;
  logic issue_accept;
  logic wb_clear;
  logic cnt_inc;
  logic cnt_dec;

  // Read / bypass / ready network.
  assign wb_write     = wb_valid && (wb_rd != ZERO_ADDR);
  assign wb_hit_rs1   = wb_valid && (wb_rd == rs1_addr);
  assign wb_hit_rs2   = wb_valid && (wb_rd == rs2_addr);
  assign wb_hit_issue = wb_valid && (wb_rd == issue_rd);

  assign rs1_data = (rs1_addr == ZERO_ADDR) ? {XLEN{1'b0}} :
                    wb_hit_rs1              ? wb_data      : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == ZERO_ADDR) ? {XLEN{1'b0}} :
                    wb_hit_rs2              ? wb_data      : regs_q[rs2_addr];

  // busy_q[0] is held at zero, so register 0 is always ready.
  assign rs1_ready = !busy_q[rs1_addr] || wb_hit_rs1;
  assign rs2_ready = !busy_q[rs2_addr] || wb_hit_rs2;

  assign issue_ready  = !flush && ((issue_rd == ZERO_ADDR) || !busy_q[issue_rd] || wb_hit_issue);
  assign issue_accept = issue_valid && issue_ready;

  // A writeback only clears a busy bit that is actually set.
  assign wb_clear = wb_write && busy_q[wb_rd];

  // Counter deltas: an issue onto a register that a same-cycle writeback
  // frees leaves that bit set, so neither delta applies in that case.
  assign cnt_inc = issue_accept && (issue_rd != ZERO_ADDR) && !busy_q[issue_rd];
  assign cnt_dec = wb_clear && !(issue_accept && (issue_rd == wb_rd));

  assign busy_cnt = busy_cnt_q;
  assign wb_err   = wb_err_q;

  // Next-state computation for storage, scoreboard, counter and error pulse.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    wb_err_d   = 1'b0;
    flush_d    = flush;

    // Data is written even during a flush.
    if (wb_write) begin
      regs_d[wb_rd] = wb_data;
    end else begin
      regs_d[wb_rd] = regs_q[wb_rd];
    end
    regs_d[0] = {XLEN{1'b0}};

    if (flush) begin
      busy_d     = {NREGS{1'b0}};
      busy_cnt_d = {(AW+1){1'b0}};
    end else begin
      // Clear first, then set: a newly accepted producer replaces the old one.
      if (wb_clear) begin
        busy_d[wb_rd] = 1'b0;
      end else begin
        busy_d[wb_rd] = busy_q[wb_rd];
      end
      if (issue_accept && (issue_rd != ZERO_ADDR)) begin
        busy_d[issue_rd] = 1'b1;
      end else begin
        busy_d[issue_rd] = busy_d[issue_rd];
      end
      busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
    busy_d[0] = 1'b0;

    if (wb_write && !busy_q[wb_rd] && !flush && !flush_q) begin
      wb_err_d = 1'b1;
    end else begin
      wb_err_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      busy_q     <= {NREGS{1'b0}};
      busy_cnt_q <= {(AW+1){1'b0}};
      wb_err_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      wb_err_q   <= wb_err_d;
      flush_q    <= flush_d;
    end
  end

endmodule : reg_file_scoreboard

// File: tb/tb_reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_file_scoreboard
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared against an array/popcount reference model.
// -----------------------------------------------------------------------------
module tb_reg_file_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic            rs1_ready, rs2_ready, issue_valid, issue_ready, wb_valid, flush, wb_err;
  logic [AW:0]     busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_err;
  bit              m_flush_prev;

  reg_file_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_valid && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_ready(input logic [AW-1:0] a);
    return (a == 0) || !m_busy[a] || (wb_valid && wb_rd == a);
  endfunction

  function automatic logic exp_issue_ready();
    return !flush && (issue_rd == 0 || !m_busy[issue_rd] || (wb_valid && wb_rd == issue_rd));
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    bit acc;
    bit err_n;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_err = 0; m_flush_prev = 0;
      return;
    end
    acc   = issue_valid && exp_issue_ready();
    err_n = wb_valid && wb_rd != 0 && !m_busy[wb_rd] && !flush && !m_flush_prev;
    if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    end else begin
      if (wb_valid) m_busy[wb_rd] = 0;
      if (acc) m_busy[issue_rd] = 1;
    end
    m_busy[0] = 0;
    m_err = err_n;
    m_flush_prev = flush;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = '0; flush = 0;
  endtask

  task automatic test_reset();
    idle(); rs1_addr = 0; rs2_addr = 0; rst = 1;
    tick();
    rst = 0; #1;
    n_vec++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
    n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_wb_err: got %b expected 0", wb_err); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
    for (int i = 1; i < NREGS; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(i); #1;
      n_vec++; if (rs1_data !== 32'h0 || rs2_ready !== 1'b1) begin n_err++; $display("FAIL reset_reg%0d: got %h/%b expected 0/1", i, rs1_data, rs2_ready); end
    end
  endtask

  task automatic test_bypass();
    idle(); rs1_addr = 5'd5; wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; #1;
    n_vec++; if (rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rs1_data); end
    tick(); idle(); #1;
    n_vec++; if (rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_next_cycle: got %h expected deadbeef", rs1_data); end
    n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL bypass_wb_err: got %b expected 1", wb_err); end
    tick();
  endtask

  task automatic test_x0();
    idle(); rs1_addr = 5'd0; wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h1234; issue_valid = 1; issue_rd = 5'd0; #1;
    n_vec++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_read: got %h expected 0", rs1_data); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL x0_issue_ready: got %b expected 1", issue_ready); end
    tick(); idle(); #1;
    n_vec++; if (busy_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++; $display("FAIL x0_cnt_err: got %0d/%b expected 0/0", busy_cnt, wb_err); end
    n_vec++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_after: got %h expected 0", rs1_data); end
  endtask

  task automatic test_raw();
    idle(); issue_valid = 1; issue_rd = 5'd7;
    tick(); idle(); rs2_addr = 5'd7; #1;
    n_vec++; if (rs2_ready !== 1'b0) begin n_err++; $display("FAIL raw_not_ready: got %b expected 0", rs2_ready); end
    n_vec++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL raw_cnt1: got %0d expected 1", busy_cnt); end
    issue_valid = 1; issue_rd = 5'd7; #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_issue_ready: got %b expected 0", issue_ready); end
    issue_valid = 0; wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h55; #1;
    n_vec++; if (rs2_ready !== 1'b1 || rs2_data !== 32'h55) begin n_err++; $display("FAIL raw_wb_bypass: got %b/%h expected 1/55", rs2_ready, rs2_data); end
    tick(); idle(); #1;
    n_vec++; if (busy_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++; $display("FAIL raw_cnt0: got %0d/%b expected 0/0", busy_cnt, wb_err); end
  endtask

  task automatic test_issue_wb_same();
    idle(); issue_valid = 1; issue_rd = 5'd3;
    tick(); idle(); #1;
    n_vec++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL same_cnt_before: got %0d expected 1", busy_cnt); end
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hA5A5; issue_valid = 1; issue_rd = 5'd3; #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL same_issue_ready: got %b expected 1", issue_ready); end
    tick(); idle(); rs1_addr = 5'd3; #1;
    n_vec++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL same_cnt_after: got %0d expected 1", busy_cnt); end
    n_vec++; if (rs1_ready !== 1'b0 || rs1_data !== 32'hA5A5) begin n_err++; $display("FAIL same_busy_data: got %b/%h expected 0/a5a5", rs1_ready, rs1_data); end
    n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL same_wb_err: got %b expected 0", wb_err); end
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h3;
    tick(); idle();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 2; i <= 6; i += 2) begin issue_valid = 1; issue_rd = AW'(i); tick(); end
    idle(); #1;
    n_vec++; if (busy_cnt !== 6'd3) begin n_err++; $display("FAIL flush_cnt3: got %0d expected 3", busy_cnt); end
    flush = 1; issue_valid = 1; issue_rd = 5'd8; #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_issue_ready: got %b expected 0", issue_ready); end
    tick(); idle(); rs1_addr = 5'd8; rs2_addr = 5'd4; #1;
    n_vec++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL flush_cnt0: got %0d expected 0", busy_cnt); end
    n_vec++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b/%b expected 1/1", rs1_ready, rs2_ready); end
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h44;
    tick(); idle(); #1;
    n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL flush_stale_wb_err: got %b expected 0", wb_err); end
    n_vec++; if (rs2_data !== 32'h44) begin n_err++; $display("FAIL flush_stale_data: got %h expected 44", rs2_data); end
  endtask

  task automatic test_wb_err();
    idle(); rs1_addr = 5'd9; wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h99;
    tick(); idle(); #1;
    n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL wb_err_pulse: got %b expected 1", wb_err); end
    n_vec++; if (rs1_data !== 32'h99) begin n_err++; $display("FAIL wb_err_data: got %h expected 99", rs1_data); end
    tick(); #1;
    n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL wb_err_one_cycle: got %b expected 0", wb_err); end
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid = 1; issue_rd = 5'd9;
    tick(); idle(); #1;
    n_vec++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL rstmid_cnt1: got %0d expected 1", busy_cnt); end
    rst = 1; issue_valid = 1; issue_rd = 5'd10; wb_valid = 1; wb_rd = 5'd11; wb_data = 32'hBAD;
    tick(); idle(); rs1_addr = 5'd9; rs2_addr = 5'd11; #1;
    n_vec++; if (busy_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++; $display("FAIL rstmid_cnt_err: got %0d/%b expected 0/0", busy_cnt, wb_err); end
    n_vec++; if (rs1_ready !== 1'b1 || rs1_data !== 32'h0) begin n_err++; $display("FAIL rstmid_x9: got %b/%h expected 1/0", rs1_ready, rs1_data); end
    n_vec++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL rstmid_x11: got %h expected 0", rs2_data); end
    rs1_addr = 5'd5; rs2_addr = 5'd10; #1;
    n_vec++; if (rs1_data !== 32'h0 || rs2_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_x5_x10: got %h/%b expected 0/1", rs1_data, rs2_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = AW'($urandom_range(0, 7));
      wb_valid    = $urandom_range(0, 1);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      rs1_addr    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      rs2_addr    = AW'($urandom_range(0, 7));
      #1;
      n_vec++; if (rs1_data !== exp_data(rs1_addr) || rs1_ready !== exp_ready(rs1_addr)) begin n_err++; $display("FAIL rand_rs1 @%0d: got %h/%b expected %h/%b", n, rs1_data, rs1_ready, exp_data(rs1_addr), exp_ready(rs1_addr)); end
      n_vec++; if (rs2_data !== exp_data(rs2_addr) || rs2_ready !== exp_ready(rs2_addr)) begin n_err++; $display("FAIL rand_rs2 @%0d: got %h/%b expected %h/%b", n, rs2_data, rs2_ready, exp_data(rs2_addr), exp_ready(rs2_addr)); end
      n_vec++; if (issue_ready !== exp_issue_ready()) begin n_err++; $display("FAIL rand_issue_ready @%0d: got %b expected %b", n, issue_ready, exp_issue_ready()); end
      tick();
      n_vec++; if (int'(busy_cnt) !== m_cnt()) begin n_err++; $display("FAIL rand_busy_cnt @%0d: got %0d expected %0d", n, busy_cnt, m_cnt()); end
      n_vec++; if (wb_err !== m_err) begin n_err++; $display("FAIL rand_wb_err @%0d: got %b expected %b", n, wb_err, m_err); end
    end
    idle();
  endtask

  initial begin
    idle(); rs1_addr = 0; rs2_addr = 0;
    for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_err = 0; m_flush_prev = 0;
    #2;
    test_reset();
    test_bypass();
    test_x0();
    test_raw();
    test_issue_wb_same();
    test_flush();
    test_wb_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_scoreboard
